// File: rtl/br_pkg.sv
// Shared encodings and the per-lane branch record for the branch resolve unit.
package br_pkg;

  // Branch condition encodings carried on br_op; 6 and 7 are reserved and behave as NONE.
  localparam logic [2:0] BR_NONE   = 3'd0;
  localparam logic [2:0] BR_UNCOND = 3'd1;
  localparam logic [2:0] BR_BEQ    = 3'd2;
  localparam logic [2:0] BR_BGT    = 3'd3;
  localparam logic [2:0] BR_BNE    = 3'd4;
  localparam logic [2:0] BR_BLE    = 3'd5;

  // Values found in the flags register.
  localparam int unsigned FLAG_EQ = 32'd1;
  localparam int unsigned FLAG_GT = 32'd2;

  // Width of the PC fields in the lane record; the top level's XLEN must match it.
  localparam int unsigned BR_XLEN = 32'd16;

  // One lane of a captured branch group.
  typedef struct packed {
    logic [2:0]         op;
    logic [BR_XLEN-1:0] target;
    logic [BR_XLEN-1:0] fallthru;
    logic               pred;
  } lane_rec_t;

  // True for the opcodes that can change control flow (and hence can mispredict).
  function automatic logic br_is_branch(input logic [2:0] op);
    logic is_br;
    case (op)
      BR_UNCOND, BR_BEQ, BR_BGT, BR_BNE, BR_BLE: is_br = 1'b1;
      default:                                   is_br = 1'b0;
    endcase
    return is_br;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Per-lane condition evaluator: turns a branch opcode and the flags snapshot
// into a taken decision. Purely combinational.
module br_cond_eval
  import br_pkg::*;
#(
  parameter int XLEN = 16
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] flags,
  output logic            taken
);

  logic is_eq_s;
  logic is_gt_s;

  assign is_eq_s = (flags == XLEN'(FLAG_EQ));
  assign is_gt_s = (flags == XLEN'(FLAG_GT));

  // Decode the condition against the flags; NONE and reserved codes are never taken.
  always_comb begin
    taken = 1'b0;
    case (op)
      BR_UNCOND: taken = 1'b1;
      BR_BEQ:    taken = is_eq_s;
      BR_BGT:    taken = is_gt_s;
      BR_BNE:    taken = ~is_eq_s;
      BR_BLE:    taken = ~is_gt_s;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-lane branch resolve unit. Stage 1 captures a lane group together with a
// snapshot of the flags register; stage 2 evaluates every lane, picks the oldest
// mispredicting lane and registers a single redirect, squashing younger lanes
// and the group queued behind it. A saturating counter tracks taken branches.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter  int LANES    = 2,
  parameter  int XLEN     = 16,
  parameter  int NREGS    = 8,
  parameter  int FLAG_IDX = 7,
  parameter  int CNT_W    = 16,
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       in_valid,
  output logic                   in_ready,
  input  logic [LANES*3-1:0]     br_op,
  input  logic [LANES*XLEN-1:0]  br_target,
  input  logic [LANES*XLEN-1:0]  br_fallthru,
  input  logic [LANES-1:0]       pred_taken,
  input  logic [NREGS*XLEN-1:0]  regval,
  input  logic                   flush,
  output logic                   redirect_valid,
  output logic [XLEN-1:0]        redirect_pc,
  output logic [LANE_W-1:0]      redirect_lane,
  output logic [CNT_W-1:0]       taken_count
);

  // Stage 1 state
  logic [LANES-1:0]  s1_valid_r;
  lane_rec_t         s1_rec_r [LANES];
  logic [XLEN-1:0]   s1_flags_r;

  // Registered outputs
  logic              in_ready_r;
  logic              redirect_valid_r;
  logic [XLEN-1:0]   redirect_pc_r;
  logic [LANE_W-1:0] redirect_lane_r;
  logic [CNT_W-1:0]  taken_count_r;

  // Combinational stage-2 results
  lane_rec_t         in_rec_s [LANES];
  logic [XLEN-1:0]   flags_in_s;
  logic [LANES-1:0]  taken_s;
  logic [LANES-1:0]  mispredict_s;
  logic [LANES-1:0]  count_mask_s;
  logic              win_found_s;
  logic [LANE_W-1:0] win_lane_s;
  logic [XLEN-1:0]   win_pc_s;
  logic [CNT_W:0]    sum_s;
  logic [CNT_W-1:0]  count_next_s;
  logic              redirect_fire_s;
  logic              capture_s;
  logic              unused_regval_s;

  assign flags_in_s = regval[FLAG_IDX*XLEN +: XLEN];
  // Only the flags slot is consumed; the rest of the register file is ignored.
  assign unused_regval_s = ^regval;

  // Unpack the flat lane buses into per-lane records.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_rec_s[i].op       = br_op[i*3 +: 3];
      in_rec_s[i].target   = br_target[i*XLEN +: XLEN];
      in_rec_s[i].fallthru = br_fallthru[i*XLEN +: XLEN];
      in_rec_s[i].pred     = pred_taken[i];
    end
  end

  // One condition evaluator per lane against the group's flags snapshot.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    br_cond_eval #(.XLEN(XLEN)) u_eval (
      .op    (s1_rec_r[g].op),
      .flags (s1_flags_r),
      .taken (taken_s[g])
    );
    assign mispredict_s[g] = s1_valid_r[g] & br_is_branch(s1_rec_r[g].op)
                           & (taken_s[g] != s1_rec_r[g].pred);
  end

  // Oldest-lane priority select; lanes younger than the winner are dropped from the count.
  always_comb begin
    win_found_s  = 1'b0;
    win_lane_s   = {LANE_W{1'b0}};
    win_pc_s     = {XLEN{1'b0}};
    count_mask_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (win_found_s) begin
        count_mask_s[i] = 1'b0;
      end else if (mispredict_s[i]) begin
        win_found_s     = 1'b1;
        win_lane_s      = LANE_W'(i);
        win_pc_s        = taken_s[i] ? s1_rec_r[i].target : s1_rec_r[i].fallthru;
        count_mask_s[i] = s1_valid_r[i];
      end else begin
        count_mask_s[i] = s1_valid_r[i];
      end
    end
  end

  // Saturating add of the surviving taken lanes to the statistics counter.
  always_comb begin
    sum_s = {1'b0, taken_count_r};
    for (int i = 0; i < LANES; i++) begin
      if (count_mask_s[i] && taken_s[i]) begin
        sum_s = sum_s + {{CNT_W{1'b0}}, 1'b1};
      end else begin
        sum_s = sum_s;
      end
    end
    if (sum_s[CNT_W]) begin
      count_next_s = {CNT_W{1'b1}};
    end else begin
      count_next_s = sum_s[CNT_W-1:0];
    end
  end

  // Flush overrides both the redirect and any capture; a redirect drops the incoming group.
  assign redirect_fire_s = win_found_s & ~flush;
  assign capture_s       = in_ready_r & (|in_valid) & ~flush & ~redirect_fire_s;

  // Stage 1 capture of the lane group and its flags snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= {LANES{1'b0}};
      s1_flags_r <= {XLEN{1'b0}};
      for (int i = 0; i < LANES; i++) begin
        s1_rec_r[i] <= '{op: 3'd0, target: {BR_XLEN{1'b0}}, fallthru: {BR_XLEN{1'b0}}, pred: 1'b0};
      end
    end else if (capture_s) begin
      s1_valid_r <= in_valid;
      s1_flags_r <= flags_in_s;
      for (int i = 0; i < LANES; i++) begin
        s1_rec_r[i] <= in_rec_s[i];
      end
    end else begin
      s1_valid_r <= {LANES{1'b0}};
    end
  end

  // Stage 2 result registers: redirect pulse, ready bubble and taken counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r       <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {XLEN{1'b0}};
      redirect_lane_r  <= {LANE_W{1'b0}};
      taken_count_r    <= {CNT_W{1'b0}};
    end else begin
      in_ready_r       <= ~redirect_fire_s;
      redirect_valid_r <= redirect_fire_s;
      redirect_pc_r    <= redirect_fire_s ? win_pc_s : {XLEN{1'b0}};
      redirect_lane_r  <= redirect_fire_s ? win_lane_s : {LANE_W{1'b0}};
      if (!flush) begin
        taken_count_r <= count_next_s;
      end else begin
        taken_count_r <= taken_count_r;
      end
    end
  end

  assign in_ready       = in_ready_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign redirect_lane  = redirect_lane_r;
  assign taken_count    = taken_count_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed lane groups push their
// expected redirect (pc, lane, cycle) into a queue; a monitor pops and compares
// whenever redirect_valid is seen. Counter and handshake values are checked inline.
module tb_branch_resolve_unit;

  localparam int LANES = 2;
  localparam int XLEN  = 16;
  localparam int NREGS = 8;
  localparam int CNT_W = 16;

  logic                  clk;
  logic                  reset;
  logic [LANES-1:0]      in_valid;
  logic                  in_ready;
  logic [LANES*3-1:0]    br_op;
  logic [LANES*XLEN-1:0] br_target;
  logic [LANES*XLEN-1:0] br_fallthru;
  logic [LANES-1:0]      pred_taken;
  logic [NREGS*XLEN-1:0] regval;
  logic                  flush;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic [0:0]            redirect_lane;
  logic [CNT_W-1:0]      taken_count;

  typedef struct {
    logic [15:0] pc;
    logic        lane;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   acc;

  branch_resolve_unit #(
    .LANES(LANES), .XLEN(XLEN), .NREGS(NREGS), .FLAG_IDX(7), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .br_op(br_op), .br_target(br_target), .br_fallthru(br_fallthru),
    .pred_taken(pred_taken), .regval(regval), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_lane(redirect_lane), .taken_count(taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every redirect against the scoreboard; idle outputs must be zero.
  always @(negedge clk) begin
    if (reset) begin
      if (redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_redirect: got pc=%0h lane=%0d at cycle %0d, expected none",
                   redirect_pc, redirect_lane, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (redirect_pc !== e.pc || redirect_lane !== e.lane || cyc != e.cyc) begin
            errors++;
            $display("FAIL redirect: got pc=%0h lane=%0d cyc=%0d expected pc=%0h lane=%0d cyc=%0d",
                     redirect_pc, redirect_lane, cyc, e.pc, e.lane, e.cyc);
          end
        end
      end else if (redirect_pc !== 16'h0000 || redirect_lane !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL idle_redirect: got pc=%0h lane=%0d expected 0 0", redirect_pc, redirect_lane);
      end else begin
        checks = checks;
      end
    end
  end

  task automatic set_flags(input logic [15:0] flg);
    regval = {8{16'hA5A5}};
    regval[7*16 +: 16] = flg;
    regval[6*16 +: 16] = ~flg;
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [2:0] op0, input logic [15:0] t0, input logic [15:0] f0,
                       input logic [2:0] op1, input logic [15:0] t1, input logic [15:0] f1,
                       input logic [1:0] p, input logic [15:0] flg);
    in_valid    = v;
    br_op       = {op1, op0};
    br_target   = {t1, t0};
    br_fallthru = {f1, f0};
    pred_taken  = p;
    set_flags(flg);
  endtask

  task automatic idle_inputs();
    in_valid = 2'b00;
    br_op    = 6'd0;
    pred_taken = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic lane, input int c);
    exp_t e;
    e.pc = pc; e.lane = lane; e.cyc = c;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    br_target = 32'd0;
    br_fallthru = 32'd0;
    idle_inputs();
    set_flags(16'd0);
    #2;
    check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("reset_redirect_pc", {16'd0, redirect_pc}, 32'd0);
    check("reset_taken_count", {16'd0, taken_count}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    check("ready_after_release", {31'd0, in_ready}, 32'd1);

    // T1: flags=EQ, lane0 BEQ predicted not taken -> redirect to 0x0040 lane 0, lane1 squashed.
    drive(2'b11, 3'd2, 16'h0040, 16'h0042, 3'd1, 16'h0100, 16'h0102, 2'b10, 16'd1);
    step(); acc = cyc;
    push_exp(16'h0040, 1'b0, acc + 1);
    idle_inputs();
    set_flags(16'd2);
    step();
    check("t1_ready_bubble", {31'd0, in_ready}, 32'd0);
    step();
    check("t1_ready_back", {31'd0, in_ready}, 32'd1);
    check("t1_count", {16'd0, taken_count}, 32'd1);

    // T2: flags=GT, lane0 BGT pred=1 correct, lane1 BEQ pred=1 wrong -> fallthru 0x0022 lane 1.
    drive(2'b11, 3'd3, 16'h0010, 16'h0012, 3'd2, 16'h0020, 16'h0022, 2'b11, 16'd2);
    step(); acc = cyc;
    push_exp(16'h0022, 1'b1, acc + 1);
    idle_inputs();
    step(); step();
    check("t2_count", {16'd0, taken_count}, 32'd2);

    // T3: back-to-back; first group mispredicts, second group is dropped.
    drive(2'b11, 3'd4, 16'h0200, 16'h0300, 3'd0, 16'h0000, 16'h0000, 2'b01, 16'd1);
    step(); acc = cyc;
    push_exp(16'h0300, 1'b0, acc + 1);
    drive(2'b11, 3'd1, 16'h0500, 16'h0502, 3'd1, 16'h0600, 16'h0602, 2'b10, 16'd1);
    step();
    check("t3_ready_bubble", {31'd0, in_ready}, 32'd0);
    idle_inputs();
    step(); step(); step();
    check("t3_count", {16'd0, taken_count}, 32'd2);

    // T4: flush the cycle after accepting a mispredicting group.
    drive(2'b11, 3'd5, 16'h0700, 16'h0600, 3'd1, 16'h0800, 16'h0802, 2'b11, 16'd2);
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    check("t4_count", {16'd0, taken_count}, 32'd2);

    // Correct predictions, reserved/NONE ops and a single-lane group: no redirects.
    drive(2'b11, 3'd2, 16'h0900, 16'h0902, 3'd3, 16'h0A00, 16'h0A02, 2'b01, 16'd1);
    step();
    drive(2'b11, 3'd6, 16'h0B00, 16'h0B02, 3'd0, 16'h0C00, 16'h0C02, 2'b11, 16'd1);
    step();
    drive(2'b01, 3'd1, 16'h0D00, 16'h0D02, 3'd2, 16'h0E00, 16'h0E02, 2'b01, 16'd1);
    step();
    idle_inputs();
    step(); step();
    check("nomis_count", {16'd0, taken_count}, 32'd4);

    // T6: reset while S1 holds a mispredicting group.
    drive(2'b11, 3'd2, 16'h0F00, 16'h0F02, 3'd0, 16'h0000, 16'h0000, 2'b00, 16'd1);
    step();
    idle_inputs();
    reset = 1'b0;
    #1;
    check("t6_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("t6_redirect_pc", {16'd0, redirect_pc}, 32'd0);
    check("t6_count", {16'd0, taken_count}, 32'd0);
    check("t6_ready", {31'd0, in_ready}, 32'd0);
    step(); step();
    reset = 1'b1;
    check("t6_ready_before_edge", {31'd0, in_ready}, 32'd0);
    step();
    check("t6_ready_after_edge", {31'd0, in_ready}, 32'd1);
    step(); step();

    // T5: saturation. 32767 two-lane UNCOND groups reach 0xFFFE, then two more groups.
    drive(2'b11, 3'd1, 16'h1000, 16'h1002, 3'd1, 16'h1100, 16'h1102, 2'b11, 16'd0);
    repeat (32767) @(posedge clk);
    #1;
    idle_inputs();
    step();
    check("t5_count_fffe", {16'd0, taken_count}, 32'h0000FFFE);
    drive(2'b11, 3'd1, 16'h1000, 16'h1002, 3'd1, 16'h1100, 16'h1102, 2'b11, 16'd0);
    step();
    idle_inputs();
    step();
    check("t5_count_sat", {16'd0, taken_count}, 32'h0000FFFF);
    drive(2'b01, 3'd1, 16'h1000, 16'h1002, 3'd0, 16'h0000, 16'h0000, 2'b01, 16'd0);
    step();
    idle_inputs();
    step();
    check("t5_count_hold", {16'd0, taken_count}, 32'h0000FFFF);

    step(); step(); step();
    check("pending_redirects", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
